// File: rtl/alu_serial.sv
// Digit-serial ALU: WIDTH-bit operands processed DIGIT bits per clock,
// LSB digit first, through one shared digit-wide datapath with a carry register.
module alu_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       select,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [2:0] {
        OP_MOV  = 3'b000,
        OP_NOT  = 3'b001,
        OP_UNA  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_SUB  = 3'b101,
        OP_ADD  = 3'b110,
        OP_ADC  = 3'b111
    } op_t;

    state_t           state, state_nxt;
    op_t              op_q;
    logic [WIDTH-1:0] work;      // operand a shifts out at the bottom, result digits shift in at the top
    logic [WIDTH-1:0] work_nxt;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             cy_q;
    logic             zacc;

    logic             accept;
    logic             last;
    logic             arith;
    logic             init_cy;
    logic [DIGIT-1:0] a_d, b_d, b_eff, dig;
    logic [DIGIT:0]   sum;
    logic             c_msb;

    assign last = (cnt == LAST);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and start acceptance
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Initial carry chosen from the incoming opcode
    always_comb begin
        init_cy = 1'b0;
        case (op_t'(select))
            OP_SUB:  init_cy = 1'b1;
            OP_ADC:  init_cy = c_in;
            default: init_cy = 1'b0;
        endcase
    end

    // One digit of the shared datapath
    always_comb begin
        a_d   = work[DIGIT-1:0];
        b_d   = b_sh[DIGIT-1:0];
        arith = op_q inside {OP_ADD, OP_SUB, OP_ADC};
        b_eff = (op_q == OP_SUB) ? ~b_d : b_d;
        sum   = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cy_q};
        c_msb = a_d[DIGIT-1] ^ b_eff[DIGIT-1] ^ sum[DIGIT-1];
        dig   = a_d;
        case (op_q)
            OP_NOT:                 dig = ~a_d;
            OP_NAND:                dig = ~(a_d & b_d);
            OP_NOR:                 dig = ~(a_d | b_d);
            OP_ADD, OP_SUB, OP_ADC: dig = sum[DIGIT-1:0];
            default:                dig = a_d;
        endcase
        // Shift through a concatenation so DIGIT == WIDTH needs no special case
        work_nxt = WIDTH'({dig, work} >> DIGIT);
    end

    // Operand/carry/counter registers and result+flag write-back on the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            b_sh   <= '0;
            op_q   <= OP_MOV;
            cnt    <= '0;
            cy_q   <= 1'b0;
            zacc   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            work <= a;
            b_sh <= b;
            op_q <= op_t'(select);
            cy_q <= init_cy;
            cnt  <= '0;
            zacc <= 1'b1;
        end else if (state == RUN) begin
            work <= work_nxt;
            b_sh <= b_sh >> DIGIT;
            cy_q <= sum[DIGIT];
            zacc <= zacc & (dig == '0);
            cnt  <= cnt + CW'(1);
            if (last) begin
                result <= work_nxt;
                carry  <= arith & sum[DIGIT];
                ovf    <= arith & (c_msb ^ sum[DIGIT]);
                zero   <= zacc & (dig == '0);
                neg    <= dig[DIGIT-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: scoreboard of expected results,
// one DIGIT=4 instance plus DIGIT=1/8/16 instances for cross-checking.
module tb_alu_serial;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_v;
    logic [15:0] a, b;
    logic [2:0]  select;
    logic        c_in;

    logic        busy4, done4, carry4, zero4, neg4, ovf4;
    logic [15:0] res4;
    logic [2:0]  busy_v, done_v, carry_v, zero_v, neg_v, ovf_v;
    logic [15:0] res_v [3];

    exp_t q4[$];
    exp_t qv[3][$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(16), .DIGIT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .select(select), .c_in(c_in),
        .busy(busy4), .done(done4), .result(res4),
        .carry(carry4), .zero(zero4), .neg(neg4), .ovf(ovf4)
    );

    alu_serial #(.WIDTH(16), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v), .a(a), .b(b), .select(select), .c_in(c_in),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]),
        .carry(carry_v[0]), .zero(zero_v[0]), .neg(neg_v[0]), .ovf(ovf_v[0])
    );

    alu_serial #(.WIDTH(16), .DIGIT(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start_v), .a(a), .b(b), .select(select), .c_in(c_in),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]),
        .carry(carry_v[1]), .zero(zero_v[1]), .neg(neg_v[1]), .ovf(ovf_v[1])
    );

    alu_serial #(.WIDTH(16), .DIGIT(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start_v), .a(a), .b(b), .select(select), .c_in(c_in),
        .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]),
        .carry(carry_v[2]), .zero(zero_v[2]), .neg(neg_v[2]), .ovf(ovf_v[2])
    );

    // Reference: whole-word arithmetic, overflow from operand/result signs
    function automatic exp_t model(input logic [2:0] sel, input logic [15:0] x, input logic [15:0] y,
                                   input logic ci);
        exp_t        e;
        logic [16:0] s;
        logic [15:0] yy;
        logic        ar;
        e  = '0;
        s  = '0;
        yy = y;
        ar = 1'b0;
        case (sel)
            3'b001: e.r = ~x;
            3'b011: e.r = ~(x & y);
            3'b100: e.r = ~(x | y);
            3'b110: begin s = {1'b0, x} + {1'b0, y}; ar = 1'b1; end
            3'b101: begin yy = ~y; s = {1'b0, x} + {1'b0, yy} + 17'd1; ar = 1'b1; end
            3'b111: begin s = {1'b0, x} + {1'b0, y} + {16'd0, ci}; ar = 1'b1; end
            default: e.r = x;
        endcase
        if (ar) begin
            e.r = s[15:0];
            e.c = s[16];
            e.v = (x[15] == yy[15]) && (e.r[15] != x[15]);
        end
        e.z = (e.r == 16'h0000);
        e.n = e.r[15];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one start pulse at the current negedge; returns one negedge later (k=0)
    task automatic launch(input logic [2:0] sel, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input bit all, input bit push);
        exp_t e;
        e = model(sel, x, y, ci);
        if (push) begin
            q4.push_back(e);
            if (all) for (int i = 0; i < 3; i++) qv[i].push_back(e);
        end
        a = x; b = y; select = sel; c_in = ci;
        start = 1'b1; start_v = all;
        @(negedge clk);
        start = 1'b0; start_v = 1'b0;
        a = 16'($urandom); b = 16'($urandom); select = 3'($urandom); c_in = 1'($urandom);
    endtask

    // Wait for completions, popping the scoreboard on each done
    task automatic collect(input bit all, input int k0);
        int       k;
        int       busy_cnt;
        bit       got4;
        bit [2:0] gotv;
        exp_t     e;
        k = k0; busy_cnt = 0; got4 = 1'b0;
        gotv = all ? 3'b000 : 3'b111;
        while (!(got4 && gotv == 3'b111) && k < 40) begin
            if (busy4) busy_cnt++;
            if (done4 && !got4) begin
                got4 = 1'b1;
                check("latency4", k, 4);
                check("busy_cycles4", busy_cnt, 4 - k0);
                e = q4.pop_front();
                check("result4", res4, e.r);
                check("flags4", {carry4, zero4, neg4, ovf4}, {e.c, e.z, e.n, e.v});
            end
            for (int i = 0; i < 3; i++) begin
                if (done_v[i] && !gotv[i]) begin
                    gotv[i] = 1'b1;
                    e = qv[i].pop_front();
                    check($sformatf("result_v%0d", i), res_v[i], e.r);
                    check($sformatf("flags_v%0d", i),
                          {carry_v[i], zero_v[i], neg_v[i], ovf_v[i]}, {e.c, e.z, e.n, e.v});
                end
            end
            if (!(got4 && gotv == 3'b111)) begin
                @(negedge clk);
                k++;
            end
        end
        check("completion", {got4, gotv}, 4'hF);
    endtask

    task automatic do_op(input logic [2:0] sel, input logic [15:0] x, input logic [15:0] y,
                         input logic ci);
        launch(sel, x, y, ci, 1'b1, 1'b1);
        collect(1'b1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1;
        bit   extra;
        rst_n = 1'b1; start = 1'b0; start_v = 1'b0;
        a = '0; b = '0; select = '0; c_in = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        check("reset4", {busy4, done4, res4, carry4, zero4, neg4, ovf4}, '0);
        check("reset_v", {busy_v, done_v, res_v[0], res_v[1], res_v[2], carry_v, zero_v, neg_v, ovf_v}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of an ADD abandons it
        launch(3'b110, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("midrun_busy", busy4, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrun_reset", {busy4, done4, res4, carry4, zero4, neg4, ovf4}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(3'b000, 16'hABCD, 16'h0000, 1'b0);
        check("mov_abcd", res4, 16'hABCD);

        // Arithmetic corner cases
        do_op(3'b110, 16'h7FFF, 16'h0001, 1'b0);
        check("add_7fff_flags", {res4, carry4, zero4, neg4, ovf4}, {16'h8000, 4'b0011});
        do_op(3'b101, 16'h0005, 16'h0005, 1'b0);
        check("sub_eq_flags", {res4, carry4, zero4, ovf4}, {16'h0000, 3'b110});
        do_op(3'b101, 16'h0000, 16'h0001, 1'b0);
        check("sub_borrow", {res4, carry4, neg4}, {16'hFFFF, 2'b01});
        do_op(3'b101, 16'h8000, 16'h0001, 1'b0);
        check("sub_ovf", {res4, ovf4}, {16'h7FFF, 1'b1});
        do_op(3'b111, 16'hFFFF, 16'h0000, 1'b1);
        check("adc_wrap", {res4, carry4, zero4}, {16'h0000, 2'b11});
        do_op(3'b110, 16'hFFFF, 16'h0000, 1'b1);
        check("add_ignores_cin", res4, 16'hFFFF);

        // Logic ops
        do_op(3'b011, 16'hF0F0, 16'hFF00, 1'b1);
        check("nand", res4, 16'h0FFF);
        do_op(3'b100, 16'hF0F0, 16'hFF00, 1'b1);
        check("nor", res4, 16'h000F);
        do_op(3'b001, 16'hF0F0, 16'hFF00, 1'b1);
        check("not", res4, 16'h0F0F);
        do_op(3'b000, 16'hF0F0, 16'hFF00, 1'b1);
        check("mov", res4, 16'hF0F0);
        do_op(3'b010, 16'hF0F0, 16'hFF00, 1'b1);
        check("unassigned", {res4, carry4, ovf4}, {16'hF0F0, 2'b00});

        // Random operations across all digit widths
        for (int i = 0; i < 12; i++)
            do_op(3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));

        // start during RUN is dropped
        launch(3'b110, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a = 16'h0000; b = 16'h0000; select = 3'b100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(1'b0, 2);
        check("ignored_start", res4, 16'h2345);
        extra = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            extra |= done4 | busy4;
        end
        check("no_extra_op", extra, 1'b0);
        check("result_held", res4, 16'h2345);

        // start in the DONE cycle is accepted; old result held meanwhile
        e1 = model(3'b101, 16'h8000, 16'h0001, 1'b0);
        launch(3'b101, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1);
        collect(1'b0, 0);
        check("done_pulse", done4, 1'b1);
        launch(3'b011, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b1);
        check("b2b_busy", {busy4, done4}, 2'b10);
        check("b2b_hold", res4, e1.r);
        collect(1'b0, 0);
        check("b2b_result", res4, 16'h0FFF);

        check("scoreboard_drain", q4.size() + qv[0].size() + qv[1].size() + qv[2].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_serial.md
# alu_serial

Multi-cycle, parametrised digit-serial ALU: operands of `WIDTH` bits are processed `DIGIT` bits per clock, least-significant digit first, through one shared digit-wide datapath with a registered carry. It keeps the team's 3-bit `select` operation encoding for single-bit slices and adds add-with-carry, status flags and a start/busy/done handshake. It sits between the register file and its write-back path wherever area matters more than single-cycle latency.

## Interface
- `WIDTH`, 16: operand/result width; must be a multiple of `DIGIT`, ≥ `DIGIT`.
- `DIGIT`, 4: bits processed per cycle; `N = WIDTH/DIGIT` digit cycles per operation.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; accepted on a rising edge when `busy`=0.
- `a`, `b` input WIDTH: operands, sampled only on the accepting edge.
- `select` input 3: operation, sampled on the accepting edge.
- `c_in` input 1: carry-in for ADC, sampled on the accepting edge.
- `busy` output 1: operation in progress; `start` ignored while high.
- `done` output 1: one-cycle pulse; `result` and flags are valid from this cycle on.
- `result` output WIDTH: held until the next accepted operation completes.
- `carry`, `zero`, `neg`, `ovf` output 1 each: flags, held alongside `result`.

## Operation
- Opcodes: 000 MOV (a); 001 NOT (~a); 011 NAND (~(a&b)); 100 NOR (~(a|b)); 110 ADD (a+b, initial carry 0); 101 SUB (a+~b, initial carry 1); 111 ADC (a+b+c_in); 010 unassigned, executes MOV.
- States: IDLE, RUN, DONE.
  - IDLE/DONE, `start`=1: latch a, b, select, initial carry; clear digit counter and zero accumulator; go to RUN.
  - DONE, `start`=0: go to IDLE.
  - RUN: compute digit k = bits [k*DIGIT +: DIGIT] with registered carry; store the digit; update carry register; AND "digit==0" into the zero accumulator; k+1. After digit N-1 is stored, go to DONE.
- Result and flags are written together on the edge entering DONE. Partial digits never appear on `result`.
- Flags:
  - `carry`: final carry-out for ADD/SUB/ADC (SUB: 1 = no borrow); 0 for logic ops.
  - `ovf`: carry into MSB XOR carry out of MSB for arithmetic ops; 0 for logic ops.
  - `zero`: result == 0 for all ops.
  - `neg`: result[WIDTH-1].
- Arithmetic is modulo 2^WIDTH; no saturation.
- `start` while `busy`=1 is dropped silently; it is neither queued nor an error.
- Reset, including mid-operation: state IDLE; `busy`, `done`, `result`, `carry`, `zero`, `neg`, `ovf` all 0; in-flight operation abandoned.

## Timing
- Accepting edge E0; `busy`=1 from E0 through E_N.
- Digit k is stored at edge E(k+1). At E_N: `busy`→0, `done`→1, `result`/flags update.
- Latency: `done` is high N cycles after the accepting edge (4 for the defaults). Throughput: one operation per N+1 cycles with back-to-back starts.
- `start` sampled high in the DONE cycle is accepted. `done` drops, `busy` rises, and the previous result stays on `result` until the new operation's E_N.
- N=1 (DIGIT=WIDTH): RUN lasts exactly one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert `rst_n`=0 mid-RUN of ADD 0x1234+0x1111 → all outputs 0 immediately. After release, a new MOV 0xABCD yields `result`=0xABCD with `done` 4 cycles after start.
- ADD 0x7FFF+0x0001 → 0x8000, carry=0, ovf=1, neg=1, zero=0; `busy` high for exactly 4 cycles.
- SUB cases:
  - 0x0005−0x0005 → 0x0000, zero=1, carry=1, ovf=0.
  - 0x0000−0x0001 → 0xFFFF, carry=0, neg=1.
  - 0x8000−0x0001 → 0x7FFF, ovf=1.
- ADC 0xFFFF+0x0000, c_in=1 → 0x0000, carry=1, zero=1. ADD with the same operands and c_in=1 → 0xFFFF (c_in ignored).
- Logic ops with a=0xF0F0, b=0xFF00:
  - NAND → 0x0FFF; NOR → 0x000F.
  - NOT → 0x0F0F; MOV → 0xF0F0; select 010 → 0xF0F0.
  - carry=ovf=0 for all of the above.
- Handshake:
  - `start` with a new opcode during RUN → ignored, original result delivered.
  - `start` in the DONE cycle → accepted, and the next `done` follows 4 cycles later.
  - Repeat the arithmetic cases with DIGIT=1, 8 and 16; results must be identical.
